// File: rtl/f_ifu_pkg.sv
// Shared fetch-stage constants and the next-PC source encoding.
package f_ifu_pkg;

    localparam logic [31:0] DEF_INSTR_START  = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_ENTRANCE = 32'h0000_4180;
    localparam logic [31:0] DEF_IM_LAST      = 32'h0000_6FFC;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_HOLD,
        NPC_ERET,
        NPC_CTI,
        NPC_EXC
    } npc_sel_e;

endpackage

// File: rtl/f_ifu_npc.sv
// f_npc: combinational next-PC selector for the fetch stage.
module f_npc
    import f_ifu_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRANCE = DEF_EXC_ENTRANCE
) (
    input  logic [31:0] pc,
    input  logic        req,
    input  logic        stall,
    input  logic        eret,
    input  logic        cti_taken,
    input  logic [31:0] target,
    input  logic [31:0] epc,
    output logic [31:0] npc
);

    npc_sel_e sel;

    // Source priority: exception entry, stall hold, ERET, taken CTI, sequential.
    always_comb begin
        sel = NPC_SEQ;
        if (req)            sel = NPC_EXC;
        else if (stall)     sel = NPC_HOLD;
        else if (eret)      sel = NPC_ERET;
        else if (cti_taken) sel = NPC_CTI;
    end

    // Mux the selected source; PC+4 wraps modulo 2^32.
    always_comb begin
        npc = pc + 32'd4;
        case (sel)
            NPC_EXC:  npc = EXC_ENTRANCE;
            NPC_HOLD: npc = pc;
            NPC_ERET: npc = epc;
            NPC_CTI:  npc = target;
            default:  npc = pc + 32'd4;
        endcase
    end

endmodule

// File: rtl/f_ifu.sv
// f_ifu: fetch-stage instruction unit. Owns the PC register, drives the
// instruction-memory address and produces the F-stage outputs.
// Optional feature macro: IFU_ADDR_CHECK_EN (fetches outside
// INSTR_START..IM_LAST also raise AdEL).
module f_ifu
    import f_ifu_pkg::*;
#(
    parameter logic [31:0] INSTR_START  = DEF_INSTR_START,
    parameter logic [31:0] EXC_ENTRANCE = DEF_EXC_ENTRANCE,
    parameter logic [31:0] IM_LAST      = DEF_IM_LAST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        stall,
    input  logic        D_BranchTaken,
    input  logic        D_JumpTaken,
    input  logic [31:0] D_NPCTarget,
    input  logic        D_IsCTI,
    input  logic        D_Eret,
    input  logic [31:0] EPC,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] F_Instr,
    output logic        F_DelaySlot,
    output logic [4:0]  F_EXCCode
);

`ifdef IFU_ADDR_CHECK_EN
    localparam logic RANGE_CHECK = 1'b1;
`else
    localparam logic RANGE_CHECK = 1'b0;
`endif

    logic [31:0] pc;
    logic [31:0] npc;
    logic        misaligned;
    logic        out_of_range;
    logic        adel;

    f_npc #(
        .EXC_ENTRANCE (EXC_ENTRANCE)
    ) u_npc (
        .pc        (pc),
        .req       (req),
        .stall     (stall),
        .eret      (D_Eret),
        .cti_taken (D_BranchTaken | D_JumpTaken),
        .target    (D_NPCTarget),
        .epc       (EPC),
        .npc       (npc)
    );

    // PC register: the only state in the fetch stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc <= INSTR_START;
        else       pc <= npc;
    end

    // Fetch address exception detection.
    always_comb begin
        misaligned   = (pc[1:0] != 2'b00);
        out_of_range = (pc < INSTR_START) || (pc > IM_LAST);
        adel         = misaligned | (RANGE_CHECK & out_of_range);
    end

    // F-stage outputs; an ERET in D turns the current fetch into a silent bubble,
    // which takes precedence over any AdEL on that wrong-path address.
    always_comb begin
        i_inst_addr = pc;
        F_PC        = pc;
        F_DelaySlot = D_IsCTI & ~D_Eret;
        F_Instr     = i_inst_rdata;
        F_EXCCode   = EXC_NONE;
        if (D_Eret) begin
            F_Instr = '0;
        end else if (adel) begin
            F_Instr   = '0;
            F_EXCCode = EXC_ADEL;
        end
    end

endmodule

// File: tb/tb_f_ifu.sv
// Testbench for f_ifu: table of per-cycle stimulus with hand-computed expected
// F-stage outputs, plus a hand-written asynchronous reset sequence.
module tb_f_ifu;

`ifdef IFU_ADDR_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req, stall, D_BranchTaken, D_JumpTaken, D_IsCTI, D_Eret;
    logic [31:0] D_NPCTarget, EPC;
    logic [31:0] i_inst_addr, i_inst_rdata;
    logic [31:0] F_PC, F_Instr;
    logic        F_DelaySlot;
    logic [4:0]  F_EXCCode;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    f_ifu dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .stall         (stall),
        .D_BranchTaken (D_BranchTaken),
        .D_JumpTaken   (D_JumpTaken),
        .D_NPCTarget   (D_NPCTarget),
        .D_IsCTI       (D_IsCTI),
        .D_Eret        (D_Eret),
        .EPC           (EPC),
        .i_inst_addr   (i_inst_addr),
        .i_inst_rdata  (i_inst_rdata),
        .F_PC          (F_PC),
        .F_Instr       (F_Instr),
        .F_DelaySlot   (F_DelaySlot),
        .F_EXCCode     (F_EXCCode)
    );

    // Instruction memory model: word content is a fixed function of the address.
    function automatic logic [31:0] im(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign i_inst_rdata = im(i_inst_addr);

    typedef struct {
        logic        req, stall, br, jmp;
        logic [31:0] tgt;
        logic        cti, eret;
        logic [31:0] epc;
        logic [31:0] exp_pc;
        logic        exp_ds;
        logic [4:0]  exp_exc;
        logic        exp_null;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rq, input logic st, input logic br, input logic jp,
                                input logic [31:0] tg, input logic ct, input logic er,
                                input logic [31:0] ep, input logic [31:0] pc, input logic ds,
                                input logic [4:0] ex, input logic nl);
        vec_t v;
        v.req = rq; v.stall = st; v.br = br; v.jmp = jp; v.tgt = tg; v.cti = ct;
        v.eret = er; v.epc = ep; v.exp_pc = pc; v.exp_ds = ds; v.exp_exc = ex; v.exp_null = nl;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        req = 0; stall = 0; D_BranchTaken = 0; D_JumpTaken = 0; D_NPCTarget = '0;
        D_IsCTI = 0; D_Eret = 0; EPC = '0;
    endtask

    initial begin
        logic [31:0] exp_instr;
        //   req st br jp tgt           cti er epc           exp_pc        ds exc               null
        add(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 0, 5'd0,            0);
        add(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 0, 5'd0,            0);
        add(0, 0, 0, 1, 32'h3010,     1, 0, 32'h0,        32'h0000_3008, 1, 5'd0,            0);
        add(0, 0, 1, 0, 32'h3100,     1, 0, 32'h0,        32'h0000_3010, 1, 5'd0,            0);
        add(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3100, 0, 5'd0,            0);
        add(0, 0, 0, 1, 32'h3020,     1, 0, 32'h0,        32'h0000_3104, 1, 5'd0,            0);
        add(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3020, 0, 5'd0,            0);
        add(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3020, 0, 5'd0,            0);
        add(0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3020, 0, 5'd0,            0);
        add(1, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3020, 0, 5'd0,            0);
        add(0, 0, 0, 0, 32'h0,        0, 1, 32'h3044,     32'h0000_4180, 0, 5'd0,            1);
        add(0, 0, 0, 0, 32'h0,        1, 1, 32'h3048,     32'h0000_3044, 0, 5'd0,            1);
        add(1, 0, 0, 0, 32'h0,        0, 1, 32'h3000,     32'h0000_3048, 0, 5'd0,            1);
        add(0, 0, 0, 1, 32'h3002,     1, 0, 32'h0,        32'h0000_4180, 1, 5'd0,            0);
        add(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3002, 0, 5'd4,            1);
        add(0, 0, 0, 0, 32'h0,        0, 1, 32'h3001,     32'h0000_3006, 0, 5'd0,            1);
        add(0, 0, 0, 1, 32'h7000,     1, 0, 32'h0,        32'h0000_3001, 1, 5'd4,            1);
        add(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,       32'h0000_7000, 1, CHK ? 5'd4 : 5'd0, CHK);
        add(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'hFFFF_FFFC, 0, CHK ? 5'd4 : 5'd0, CHK);
        add(0, 1, 1, 0, 32'h5000,     1, 0, 32'h0,        32'h0000_0000, 1, CHK ? 5'd4 : 5'd0, CHK);
        add(0, 0, 1, 0, 32'h3FFC,     1, 0, 32'h0,        32'h0000_0000, 1, CHK ? 5'd4 : 5'd0, CHK);
        add(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3FFC, 0, 5'd0,            0);

        // Power-on reset, released away from a clock edge.
        drive_idle();
        reset = 1'b1;
        #13;
        chk("reset_pc", -1, F_PC, 32'h0000_3000);
        chk("reset_exc", -1, {27'd0, F_EXCCode}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            req = vecs[i].req; stall = vecs[i].stall;
            D_BranchTaken = vecs[i].br; D_JumpTaken = vecs[i].jmp;
            D_NPCTarget = vecs[i].tgt; D_IsCTI = vecs[i].cti;
            D_Eret = vecs[i].eret; EPC = vecs[i].epc;
            #1;
            exp_instr = vecs[i].exp_null ? 32'd0 : im(vecs[i].exp_pc);
            chk("F_PC", i, F_PC, vecs[i].exp_pc);
            chk("i_inst_addr", i, i_inst_addr, vecs[i].exp_pc);
            chk("F_Instr", i, F_Instr, exp_instr);
            chk("F_DelaySlot", i, {31'd0, F_DelaySlot}, {31'd0, vecs[i].exp_ds});
            chk("F_EXCCode", i, {27'd0, F_EXCCode}, {27'd0, vecs[i].exp_exc});
        end

        // Mid-operation asynchronous reset: PC forced between clock edges.
        @(negedge clk);
        drive_idle();
        #1;
        chk("pre_reset_pc", -2, F_PC, 32'h0000_4000);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_pc", -2, F_PC, 32'h0000_3000);
        @(posedge clk);
        #1;
        chk("reset_hold_pc", -2, F_PC, 32'h0000_3000);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("release_pc", -2, F_PC, 32'h0000_3000);
        chk("release_instr", -2, F_Instr, im(32'h0000_3000));
        @(posedge clk);
        #1;
        chk("seq1_pc", -2, F_PC, 32'h0000_3004);
        @(posedge clk);
        #1;
        chk("seq2_pc", -2, F_PC, 32'h0000_3008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
